// File: rtl/axi_tdd_ng_pkg.sv
// Shared TDD controller definitions used by the channel generators and the
// edge-capture monitor.
package axi_tdd_ng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    WAITING = 2'b10,
    RUNNING = 2'b11
  } state_t;

endpackage

// File: rtl/axi_tdd_ng_edge_capture.sv
// Measures when an active-level TDD line asserts/de-asserts within each frame
// and reports one result per frame through a single-entry output buffer.
module axi_tdd_ng_edge_capture #(
  parameter int REGISTER_WIDTH = 32,
  parameter int CAPTURE_OFFSET = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [REGISTER_WIDTH-1:0] tdd_counter,
  input  axi_tdd_ng_pkg::state_t    tdd_cstate,
  input  logic                      tdd_enable,
  input  logic                      tdd_restart,
  input  logic                      ch_en,
  input  logic                      ch_pol,
  input  logic                      sig_in,
  input  logic                      cap_ready,
  input  logic                      ovf_clr,
  output logic                      cap_valid,
  output logic [REGISTER_WIDTH-1:0] cap_t_high,
  output logic [REGISTER_WIDTH-1:0] cap_t_low,
  output logic                      cap_high_seen,
  output logic                      cap_low_seen,
  output logic                      cap_multi,
  output logic                      overflow,
  output logic                      dbg_state_o
);

  // Handshake: a result transfers on any cycle with cap_valid=1 and
  // cap_ready=1; the payload is held stable while cap_valid=1.

  typedef enum logic {S_IDLE, S_MEASURE} fsm_t;

  fsm_t                      state_q, state_d;
  logic                      sig_q, sig_prev_q;
  logic [REGISTER_WIDTH-1:0] cnt_q;

  logic [REGISTER_WIDTH-1:0] ws_t_high_q, ws_t_high_d;
  logic [REGISTER_WIDTH-1:0] ws_t_low_q, ws_t_low_d;
  logic                      ws_high_q, ws_high_d;
  logic                      ws_low_q, ws_low_d;
  logic                      ws_multi_q, ws_multi_d;

  logic                      out_valid_q, out_valid_d;
  logic [REGISTER_WIDTH-1:0] out_t_high_q, out_t_high_d;
  logic [REGISTER_WIDTH-1:0] out_t_low_q, out_t_low_d;
  logic                      out_high_q, out_high_d;
  logic                      out_low_q, out_low_d;
  logic                      out_multi_q, out_multi_d;
  logic                      ovf_q, ovf_d;

  logic                      running, edge_act, edge_rise, edge_fall;
  logic                      close, clear, accumulate, offer, load_ok;
  logic [REGISTER_WIDTH-1:0] cap_val;

  assign running   = (tdd_cstate == axi_tdd_ng_pkg::RUNNING);
  assign edge_act  = running && ch_en && (sig_q != sig_prev_q);
  assign edge_rise = edge_act && (sig_q != ch_pol);
  assign edge_fall = edge_act && (sig_q == ch_pol);
  // Offset undoes the loopback latency; wraps modulo 2^W by design.
  assign cap_val   = cnt_q - REGISTER_WIDTH'(CAPTURE_OFFSET);

  always_comb begin
    state_d     = state_q;
    close       = 1'b0;
    clear       = 1'b0;
    accumulate  = 1'b0;
    ws_t_high_d = ws_t_high_q;
    ws_t_low_d  = ws_t_low_q;
    ws_high_d   = ws_high_q;
    ws_low_d    = ws_low_q;
    ws_multi_d  = ws_multi_q;

    case (state_q)
      S_IDLE: begin
        if (running) begin
          clear   = 1'b1;
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (!running) begin
          close   = 1'b1;
          state_d = S_IDLE;
        end else begin
          accumulate = 1'b1;
          if (tdd_restart) begin
            close = 1'b1;
            clear = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      ws_t_high_d = '0;
      ws_t_low_d  = '0;
      ws_high_d   = 1'b0;
      ws_low_d    = 1'b0;
      ws_multi_d  = 1'b0;
    end

    // Applied after the clear so an edge on the restart cycle opens the new frame.
    if (accumulate && edge_rise) begin
      if (!ws_high_d) begin
        ws_t_high_d = cap_val;
        ws_high_d   = 1'b1;
      end else begin
        ws_multi_d = 1'b1;
      end
    end
    if (accumulate && edge_fall) begin
      if (!ws_low_d) begin
        ws_t_low_d = cap_val;
        ws_low_d   = 1'b1;
      end else begin
        ws_multi_d = 1'b1;
      end
    end
  end

  always_comb begin
    offer        = tdd_enable && close && (ws_high_q || ws_low_q);
    load_ok      = !out_valid_q || cap_ready;
    out_valid_d  = out_valid_q && !cap_ready;
    out_t_high_d = out_t_high_q;
    out_t_low_d  = out_t_low_q;
    out_high_d   = out_high_q;
    out_low_d    = out_low_q;
    out_multi_d  = out_multi_q;
    ovf_d        = ovf_q && !ovf_clr;
    if (offer && load_ok) begin
      out_valid_d  = 1'b1;
      out_t_high_d = ws_t_high_q;
      out_t_low_d  = ws_t_low_q;
      out_high_d   = ws_high_q;
      out_low_d    = ws_low_q;
      out_multi_d  = ws_multi_q;
    end
    if (offer && !load_ok) begin
      ovf_d = 1'b1;
    end
  end

  // tdd_enable low behaves like reset for everything except the sticky overflow.
  always_ff @(posedge clk) begin
    if (!resetn || !tdd_enable) begin
      state_q      <= S_IDLE;
      sig_q        <= ch_pol;
      sig_prev_q   <= ch_pol;
      cnt_q        <= '0;
      ws_t_high_q  <= '0;
      ws_t_low_q   <= '0;
      ws_high_q    <= 1'b0;
      ws_low_q     <= 1'b0;
      ws_multi_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_t_high_q <= '0;
      out_t_low_q  <= '0;
      out_high_q   <= 1'b0;
      out_low_q    <= 1'b0;
      out_multi_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sig_q        <= sig_in;
      sig_prev_q   <= sig_q;
      cnt_q        <= tdd_counter;
      ws_t_high_q  <= ws_t_high_d;
      ws_t_low_q   <= ws_t_low_d;
      ws_high_q    <= ws_high_d;
      ws_low_q     <= ws_low_d;
      ws_multi_q   <= ws_multi_d;
      out_valid_q  <= out_valid_d;
      out_t_high_q <= out_t_high_d;
      out_t_low_q  <= out_t_low_d;
      out_high_q   <= out_high_d;
      out_low_q    <= out_low_d;
      out_multi_q  <= out_multi_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign cap_valid     = out_valid_q;
  assign cap_t_high    = out_t_high_q;
  assign cap_t_low     = out_t_low_q;
  assign cap_high_seen = out_high_q;
  assign cap_low_seen  = out_low_q;
  assign cap_multi     = out_multi_q;
  assign overflow      = ovf_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_axi_tdd_ng_edge_capture.sv
// Directed bench for axi_tdd_ng_edge_capture: a modelled generator line is
// played against a 0..99 frame counter and each frame result is checked.
module tb_axi_tdd_ng_edge_capture;

  localparam int W = 32;

  logic                   clk;
  logic                   resetn;
  logic [W-1:0]           tdd_counter;
  axi_tdd_ng_pkg::state_t tdd_cstate;
  logic                   tdd_enable;
  logic                   tdd_restart;
  logic                   ch_en;
  logic                   ch_pol;
  logic                   sig_in;
  logic                   cap_ready;
  logic                   ovf_clr;
  logic                   cap_valid;
  logic [W-1:0]           cap_t_high;
  logic [W-1:0]           cap_t_low;
  logic                   cap_high_seen;
  logic                   cap_low_seen;
  logic                   cap_multi;
  logic                   overflow;
  logic                   dbg_state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Generator model: up to two pulses, each active for (counter-2) in [th, tl).
  logic p1_on, p2_on;
  int   p1_th, p1_tl, p2_th, p2_tl;

  axi_tdd_ng_edge_capture #(
    .REGISTER_WIDTH(W),
    .CAPTURE_OFFSET(2)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .tdd_counter  (tdd_counter),
    .tdd_cstate   (tdd_cstate),
    .tdd_enable   (tdd_enable),
    .tdd_restart  (tdd_restart),
    .ch_en        (ch_en),
    .ch_pol       (ch_pol),
    .sig_in       (sig_in),
    .cap_ready    (cap_ready),
    .ovf_clr      (ovf_clr),
    .cap_valid    (cap_valid),
    .cap_t_high   (cap_t_high),
    .cap_t_low    (cap_t_low),
    .cap_high_seen(cap_high_seen),
    .cap_low_seen (cap_low_seen),
    .cap_multi    (cap_multi),
    .overflow     (overflow),
    .dbg_state_o  (dbg_state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic line_level(input int c);
    logic act;
    act = (p1_on && (c - 2) >= p1_th && (c - 2) < p1_tl) ||
          (p2_on && (c - 2) >= p2_th && (c - 2) < p2_tl);
    return ch_pol ^ act;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_counter(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      tdd_counter = W'(c);
      tdd_restart = (c == 0);
      sig_in      = line_level(c);
      tick();
    end
    tdd_restart = 1'b0;
  endtask

  task automatic set_pulses(input logic on1, input int th1, input int tl1,
                            input logic on2, input int th2, input int tl2);
    p1_on = on1; p1_th = th1; p1_tl = tl1;
    p2_on = on2; p2_th = th2; p2_tl = tl2;
  endtask

  task automatic restart_channel(input logic pol);
    tdd_enable  = 1'b0;
    tdd_restart = 1'b0;
    ch_pol      = pol;
    sig_in      = pol;
    tick();
    tick();
    tdd_enable = 1'b1;
  endtask

  task automatic chk_result(input string tag, input logic [W-1:0] th, input logic [W-1:0] tl,
                            input logic hs, input logic ls, input logic mu);
    chk({tag, ".valid"}, W'(cap_valid), 1);
    chk({tag, ".t_high"}, cap_t_high, th);
    chk({tag, ".t_low"}, cap_t_low, tl);
    chk({tag, ".high_seen"}, W'(cap_high_seen), W'(hs));
    chk({tag, ".low_seen"}, W'(cap_low_seen), W'(ls));
    chk({tag, ".multi"}, W'(cap_multi), W'(mu));
  endtask

  initial begin
    resetn      = 1'b0;
    tdd_counter = '0;
    tdd_cstate  = axi_tdd_ng_pkg::IDLE;
    tdd_enable  = 1'b0;
    tdd_restart = 1'b0;
    ch_en       = 1'b0;
    ch_pol      = 1'b0;
    sig_in      = 1'b0;
    cap_ready   = 1'b0;
    ovf_clr     = 1'b0;
    set_pulses(1'b0, 0, 0, 1'b0, 0, 0);
    tick();
    tick();

    // Reset state
    chk("rst.valid", W'(cap_valid), 0);
    chk("rst.t_high", cap_t_high, 0);
    chk("rst.t_low", cap_t_low, 0);
    chk("rst.seen", W'({cap_high_seen, cap_low_seen, cap_multi}), 0);
    chk("rst.overflow", W'(overflow), 0);
    chk("rst.state", W'(dbg_state_o), 0);

    // Loopback, pol=0, t_high=10, t_low=50
    resetn     = 1'b1;
    tdd_enable = 1'b1;
    ch_en      = 1'b1;
    tdd_cstate = axi_tdd_ng_pkg::RUNNING;
    set_pulses(1'b1, 10, 50, 1'b0, 0, 0);
    run_counter(0, 99);
    chk("lb.no_result_first_frame", W'(cap_valid), 0);
    chk("lb.state_measure", W'(dbg_state_o), 1);
    run_counter(0, 0);
    chk_result("lb", 10, 50, 1'b1, 1'b1, 1'b0);
    cap_ready = 1'b1;
    run_counter(1, 1);
    cap_ready = 1'b0;
    chk("lb.pop", W'(cap_valid), 0);

    // Inverted polarity: line low for counter 20..30
    restart_channel(1'b1);
    set_pulses(1'b1, 20, 30, 1'b0, 0, 0);
    run_counter(0, 99);
    run_counter(0, 0);
    chk_result("inv", 20, 30, 1'b1, 1'b1, 1'b0);

    // Two pulses in one frame
    restart_channel(1'b0);
    set_pulses(1'b1, 10, 20, 1'b1, 40, 60);
    run_counter(0, 99);
    run_counter(0, 0);
    chk_result("two", 10, 20, 1'b1, 1'b1, 1'b1);

    // Consumer stalled across a second close: first result kept, overflow set
    set_pulses(1'b1, 5, 15, 1'b0, 0, 0);
    run_counter(1, 99);
    run_counter(0, 0);
    chk_result("ovf.retain", 10, 20, 1'b1, 1'b1, 1'b1);
    chk("ovf.set", W'(overflow), 1);
    ovf_clr = 1'b1;
    run_counter(1, 1);
    ovf_clr = 1'b0;
    chk("ovf.clear", W'(overflow), 0);
    run_counter(2, 99);
    ovf_clr = 1'b1;
    run_counter(0, 0);
    ovf_clr = 1'b0;
    chk("ovf.set_wins", W'(overflow), 1);
    chk("ovf.still_old", cap_t_high, 10);
    ovf_clr = 1'b1;
    run_counter(1, 1);
    ovf_clr = 1'b0;
    chk("ovf.clear2", W'(overflow), 0);
    run_counter(2, 99);
    cap_ready = 1'b1;
    run_counter(0, 0);
    chk_result("pop_load", 5, 15, 1'b1, 1'b1, 1'b0);
    chk("pop_load.overflow", W'(overflow), 0);
    run_counter(1, 1);
    chk("pop_load.drain", W'(cap_valid), 0);
    cap_ready = 1'b0;

    // Edge on the restart cycle belongs to the new frame; fall wraps below 0
    restart_channel(1'b0);
    set_pulses(1'b1, 97, 200, 1'b0, 0, 0);
    run_counter(0, 99);
    run_counter(0, 0);
    chk("rs_edge.closed_empty", W'(cap_valid), 0);
    set_pulses(1'b0, 0, 0, 1'b0, 0, 0);
    run_counter(1, 99);
    run_counter(0, 0);
    chk_result("rs_edge.next", 97, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);
    cap_ready = 1'b1;
    run_counter(1, 1);
    cap_ready = 1'b0;

    // tdd_enable dropped mid-frame after an assertion
    restart_channel(1'b0);
    set_pulses(1'b1, 10, 50, 1'b0, 0, 0);
    run_counter(0, 30);
    tdd_enable = 1'b0;
    tick();
    chk("dis.valid", W'(cap_valid), 0);
    chk("dis.state", W'(dbg_state_o), 0);
    chk("dis.high_seen", W'(cap_high_seen), 0);
    tick();
    tdd_enable = 1'b1;
    set_pulses(1'b1, -1, 3, 1'b0, 0, 0);
    run_counter(0, 99);
    chk("dis.no_partial", W'(cap_valid), 0);
    run_counter(0, 0);
    chk_result("dis.clean", 32'hFFFF_FFFF, 3, 1'b1, 1'b1, 1'b0);

    // ch_en dropped mid-frame, then the frame closes by leaving RUNNING
    cap_ready = 1'b1;
    set_pulses(1'b1, 10, 50, 1'b0, 0, 0);
    run_counter(1, 1);
    cap_ready = 1'b0;
    chk("chen.pop", W'(cap_valid), 0);
    run_counter(2, 30);
    ch_en = 1'b0;
    run_counter(31, 60);
    tdd_cstate = axi_tdd_ng_pkg::ARMED;
    tick();
    chk_result("chen", 10, 0, 1'b1, 1'b0, 1'b0);
    chk("chen.state_idle", W'(dbg_state_o), 0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_tdd_ng_edge_capture.md
# axi_tdd_ng_edge_capture

Measurement counterpart of a TDD channel output. It samples one external, active-level TDD control line against the shared TDD frame counter and records when the line asserted and de-asserted within each frame. Per frame it reports one result through a valid/ready handshake. It sits beside the TDD channel generators, sharing counter, state and restart. Looping a generator channel back into it returns that channel's programmed t_high/t_low exactly.

## Interface
- REGISTER_WIDTH, 32, width of counter and captured values
- CAPTURE_OFFSET, 2, cycles subtracted from the sampled counter; the loopback path latency
- clk  input  1  block clock
- resetn  input  1  synchronous active-low reset
- tdd_counter  input  REGISTER_WIDTH  shared frame counter
- tdd_cstate  input  axi_tdd_ng_pkg::state_t  TDD controller state; only RUNNING enables capture
- tdd_enable  input  1  global enable; low acts as reset of all state except overflow
- tdd_restart  input  1  single-cycle frame-start pulse
- ch_en  input  1  capture enable
- ch_pol  input  1  idle (de-asserted) level of sig_in
- sig_in  input  1  monitored line, synchronous to clk
- cap_ready  input  1  consumer accepts result
- ovf_clr  input  1  clears overflow
- cap_valid  output  1  result held in output buffer
- cap_t_high  output  REGISTER_WIDTH  counter value of first assertion
- cap_t_low  output  REGISTER_WIDTH  counter value of first de-assertion
- cap_high_seen  output  1  assertion captured in frame
- cap_low_seen  output  1  de-assertion captured in frame
- cap_multi  output  1  more than one edge of a kind in frame
- overflow  output  1  sticky: a frame result was dropped

## Operation
- sig_r samples sig_in every cycle. cnt_r samples tdd_counter in the same cycle.
- When tdd_enable=0, sig_r loads ch_pol.
- An edge is active when cstate==RUNNING, ch_en=1 and sig_r differs from its previous value.
- Assertion edge: new level = ~ch_pol. De-assertion edge: new level = ch_pol.
- Captured value = cnt_r − CAPTURE_OFFSET, modulo 2^REGISTER_WIDTH.
- Working set per frame: t_high, t_low, high_seen, low_seen, multi.
- Only the first edge of each kind is stored. A repeated edge of the same kind sets multi.
- States:
  - IDLE: waiting for RUNNING. On cstate==RUNNING, clear the working set and go to MEASURE.
  - MEASURE: accumulate edges.
    - tdd_restart closes the frame, clears the working set and stays in MEASURE.
    - cstate leaving RUNNING closes the frame and goes to IDLE.
- Frame close with high_seen|low_seen=1 offers the working set to the output buffer. A frame with no edges produces no result.
- Output buffer:
  - Loads when empty, or when cap_valid&cap_ready occurs in the same cycle.
  - Otherwise the new result is dropped, the old result is kept and overflow is set.
  - Contents are stable while cap_valid=1.
- overflow clears only on ovf_clr or resetn=0. If set and clear occur in the same cycle, set wins.
- tdd_enable=0: returns to IDLE, clears the working set and cap_valid, keeps overflow.

## Timing
- All outputs reset to 0. The sig_r history resets to ch_pol.
- Edge to working-set update: 1 cycle after the sig_r change.
- Close to cap_valid: cap_valid is high on the cycle after the close cycle.
- Pop: cap_valid&cap_ready at edge N. cap_valid is low after N unless a load happens at N.
- Edge and tdd_restart in the same cycle: the edge belongs to the new frame. The closed frame excludes it.
- ch_en deasserting mid-frame: edges after that point are ignored. Frame close still reports what was already captured.
- resetn or tdd_enable low mid-frame: the partial result is discarded with no cap_valid.
- Counter near 0 with offset 2: cnt_r=1 gives 2^W−1. No saturation.

## Test plan
- Loopback with a generator channel: pol=0, t_high=10, t_low=50, counter 0..99 restart. At the second restart: cap_valid=1, t_high=10, t_low=50, seen=1/1, multi=0.
- pol=1, inverted line: low pulse from counter 20 to 30, sampled with offset. Result: t_high=20, t_low=30.
- Two pulses in one frame (10–20, 40–60). Result: t_high=10, t_low=20, multi=1.
- cap_ready held low across 2 frame closes. First result is retained, overflow=1 after the 2nd close. ovf_clr=1 clears it.
- Edge on the restart cycle. Closed frame: seen=0/0, no cap_valid. Next frame captures that edge.
- tdd_enable dropped mid-frame after an assertion. No cap_valid, state is IDLE, and the next RUNNING frame measures cleanly.
